// File: rtl/ysyx_22040125_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, size codes,
// writeback error codes and the bit positions inside the one-hot op selects.
package ysyx_22040125_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    // l_bhw is {lb,lbu,lh,lhu,lw,lwu}; s_bhwd is {sb,sh,sw}
    localparam int unsigned L_LB  = 5;
    localparam int unsigned L_LBU = 4;
    localparam int unsigned L_LH  = 3;
    localparam int unsigned L_LHU = 2;
    localparam int unsigned L_LW  = 1;
    localparam int unsigned L_LWU = 0;
    localparam int unsigned S_SB  = 2;
    localparam int unsigned S_SH  = 1;
    localparam int unsigned S_SW  = 0;

    function automatic logic is_misaligned(input lsu_size_e size, input logic [2:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040125_lsu_align.sv
// Combinational datapath of the LSU: request-side size decode, alignment check,
// strobe/write-data lane shift, and response-side load extract with extension.
module ysyx_22040125_lsu_align
    import ysyx_22040125_lsu_pkg::*;
(
    input  logic        is_load,
    input  logic [5:0]  l_bhw,
    input  logic [2:0]  s_bhwd,
    input  logic [2:0]  req_off,
    input  logic [63:0] req_wdata,
    output lsu_size_e   req_size,
    output logic        req_signed,
    output logic        req_misalign,
    output logic [7:0]  req_wstrb,
    output logic [63:0] req_wdata_sh,
    input  lsu_size_e   rsp_size,
    input  logic        rsp_signed,
    input  logic [2:0]  rsp_off,
    input  logic [63:0] rsp_rdata,
    output logic [63:0] ld_data
);

    logic [63:0] rsp_sh;

    always_comb begin
        req_size   = SZ_D;
        req_signed = 1'b1;
        if (is_load) begin
            if (l_bhw[L_LB] | l_bhw[L_LBU])      req_size = SZ_B;
            else if (l_bhw[L_LH] | l_bhw[L_LHU]) req_size = SZ_H;
            else if (l_bhw[L_LW] | l_bhw[L_LWU]) req_size = SZ_W;
            req_signed = !(l_bhw[L_LBU] | l_bhw[L_LHU] | l_bhw[L_LWU]);
        end else begin
            if (s_bhwd[S_SB])      req_size = SZ_B;
            else if (s_bhwd[S_SH]) req_size = SZ_H;
            else if (s_bhwd[S_SW]) req_size = SZ_W;
        end
    end

    assign req_misalign = is_misaligned(req_size, req_off);

    always_comb begin
        case (req_size)
            SZ_B:    req_wstrb = 8'h01 << req_off;
            SZ_H:    req_wstrb = 8'h03 << req_off;
            SZ_W:    req_wstrb = 8'h0F << req_off;
            default: req_wstrb = 8'hFF;
        endcase
    end

    assign req_wdata_sh = req_wdata << {req_off, 3'b000};
    assign rsp_sh       = rsp_rdata >> {rsp_off, 3'b000};

    always_comb begin
        case (rsp_size)
            SZ_B:    ld_data = rsp_signed ? {{56{rsp_sh[7]}},  rsp_sh[7:0]}  : {56'd0, rsp_sh[7:0]};
            SZ_H:    ld_data = rsp_signed ? {{48{rsp_sh[15]}}, rsp_sh[15:0]} : {48'd0, rsp_sh[15:0]};
            SZ_W:    ld_data = rsp_signed ? {{32{rsp_sh[31]}}, rsp_sh[31:0]} : {32'd0, rsp_sh[31:0]};
            default: ld_data = rsp_sh;
        endcase
    end

endmodule

// File: rtl/ysyx_22040125_lsu.sv
// Load/store unit: accepts one EXU access, runs the memory request/response
// handshake with a response timeout, and hands the result to write-back.
//
// state | meaning
// IDLE  | ready for EXU; decode and early error check on accept
// REQ   | mem_req_valid high, request fields held until mem_req_ready
// WAIT  | waiting for mem_rsp_valid, counting toward TIMEOUT
// RESP  | wb_valid high, result held until wb_ready
module ysyx_22040125_lsu
    import ysyx_22040125_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [63:0] ex_addr,
    input  logic [63:0] ex_wdata,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [5:0]  l_bhw,
    input  logic [2:0]  s_bhwd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_rdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [63:0] wb_rdata,
    output logic [1:0]  wb_err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    lsu_state_e  state, state_next;
    lsu_size_e   req_size, size_q;
    logic        req_signed, req_misalign, illegal;
    logic [7:0]  req_wstrb;
    logic [63:0] req_wdata_sh, ld_data;
    logic        op_load_q, signed_q;
    logic [2:0]  off_q;
    logic [7:0]  cnt_q, cnt_inc;
    logic        unused_addr;

    assign unused_addr = ^ex_addr[63:32];
    assign illegal     = (is_load == is_store);
    assign cnt_inc     = cnt_q + 8'd1;

    ysyx_22040125_lsu_align u_align (
        .is_load      (is_load),
        .l_bhw        (l_bhw),
        .s_bhwd       (s_bhwd),
        .req_off      (ex_addr[2:0]),
        .req_wdata    (ex_wdata),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_misalign (req_misalign),
        .req_wstrb    (req_wstrb),
        .req_wdata_sh (req_wdata_sh),
        .rsp_size     (size_q),
        .rsp_signed   (signed_q),
        .rsp_off      (off_q),
        .rsp_rdata    (mem_rsp_rdata),
        .ld_data      (ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (ex_valid) state_next = (illegal || req_misalign) ? ST_RESP : ST_REQ;
            ST_REQ:  if (mem_req_ready) state_next = ST_WAIT;
            ST_WAIT: if (mem_rsp_valid || cnt_inc == TIMEOUT_CNT) state_next = ST_RESP;
            ST_RESP: if (wb_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign ex_ready      = (state == ST_IDLE);
    assign mem_req_valid = (state == ST_REQ);
    assign wb_valid      = (state == ST_RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            wb_rdata  <= '0;
            wb_err    <= ERR_OK;
            cnt_q     <= '0;
            op_load_q <= 1'b0;
            signed_q  <= 1'b0;
            off_q     <= '0;
            size_q    <= SZ_B;
        end else begin
            case (state)
                ST_IDLE: if (ex_valid) begin
                    op_load_q <= is_load;
                    off_q     <= ex_addr[2:0];
                    size_q    <= req_size;
                    signed_q  <= req_signed;
                    wb_rdata  <= '0;
                    if (illegal) begin
                        wb_err <= ERR_ILLEGAL;
                    end else if (req_misalign) begin
                        wb_err <= ERR_MISALIGN;
                    end else begin
                        // Request fields only change here, so they stay put for all of REQ
                        mem_addr  <= {ex_addr[31:3], 3'b000};
                        mem_wen   <= is_store;
                        mem_wdata <= is_store ? req_wdata_sh : '0;
                        mem_wstrb <= is_store ? req_wstrb : '0;
                    end
                end
                ST_REQ: if (mem_req_ready) cnt_q <= '0;
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        wb_err   <= ERR_OK;
                        wb_rdata <= op_load_q ? ld_data : '0;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == TIMEOUT_CNT) begin
                            wb_err   <= ERR_TIMEOUT;
                            wb_rdata <= '0;
                        end
                    end
                end
                ST_RESP: if (wb_ready) begin
                    wb_err   <= ERR_OK;
                    wb_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
